// File: rtl/mac_ch_lpbk_pkg.sv
// Shared constants, lane state encoding and the pattern segment packer for the
// MAC-side channel loopback generator/checker.
package mac_ch_lpbk_pkg;

  localparam int SEG_W = 16;
  localparam int TAG_W = 4;
  localparam int CNT_W = 12;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} lane_state_e;

  function automatic logic [SEG_W-1:0] pack_seg(input logic [TAG_W-1:0] tag,
                                                input logic [CNT_W-1:0] cnt);
    return {tag, cnt};
  endfunction

endpackage

// File: rtl/mac_ch_lpbk_chk_if.sv
// Channel data path bundle between the loopback checker (master) and the
// MAC-side channel buses (slave).
interface mac_ch_lpbk_chk_if #(
  parameter int NCH = 4,
  parameter int W   = 80
);
  logic [NCH-1:0]   tx_transfer_en;
  logic [NCH-1:0]   rx_transfer_en;
  logic             m_rx_align_done;
  logic [NCH*W-1:0] data_in;
  logic [NCH*W-1:0] data_out;

  modport master (
    input  tx_transfer_en, rx_transfer_en, m_rx_align_done, data_out,
    output data_in
  );

  modport slave (
    output tx_transfer_en, rx_transfer_en, m_rx_align_done, data_out,
    input  data_in
  );
endinterface

// File: rtl/mac_ch_lpbk_lane.sv
// One channel of the loopback tester: counter-pattern generator, lock FSM and
// saturating error/good counters. MAC_CH_LPBK_ERR_INJ_EN adds bit-0 TX error injection.
//
// state  | meaning
// SEARCH | waiting for a well-formed word to seed the expected count
// VERIFY | counting consecutive matches toward lock
// LOCKED | tracking; matches count good, mismatches count errors
module mac_ch_lpbk_lane
  import mac_ch_lpbk_pkg::*;
#(
  parameter int W          = 80,
  parameter int TAG        = 1,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4
) (
  input  logic          m_wr_clk,
  input  logic          m_wr_rst,
  input  logic          tx_en,
  input  logic          rx_v,
  input  logic          clr_cnt,
`ifdef MAC_CH_LPBK_ERR_INJ_EN
  input  logic          inj_err,
`endif
  output logic [W-1:0]  tx_word,
  input  logic [W-1:0]  rx_word,
  output logic          locked,
  output logic [15:0]   err_cnt,
  output logic [31:0]   good_cnt
);

  localparam int NSEG = W / SEG_W;
  localparam logic [TAG_W-1:0] TAG_V     = TAG_W'(TAG);
  localparam logic [7:0]       RUN_LOAD  = 8'(LOCK_CNT - 1);
  localparam logic [7:0]       MISS_LOAD = 8'(UNLOCK_CNT);

  function automatic logic [W-1:0] pat_word(input logic [CNT_W-1:0] cnt);
    return {NSEG{pack_seg(TAG_V, cnt)}};
  endfunction

  logic [CNT_W-1:0] tx_cnt;
  logic [W-1:0]     tx_pat;

  always_comb begin
    tx_pat = pat_word(tx_cnt);
`ifdef MAC_CH_LPBK_ERR_INJ_EN
    tx_pat[0] = tx_pat[0] ^ inj_err;
`endif
  end

  always_ff @(posedge m_wr_clk) begin
    if (m_wr_rst) begin
      tx_cnt  <= '0;
      tx_word <= '0;
    end else if (tx_en) begin
      tx_cnt  <= tx_cnt + CNT_W'(1);
      tx_word <= tx_pat;
    end else begin
      tx_word <= '0;
    end
  end

  lane_state_e      state;
  logic [W-1:0]     rx_q;
  logic             rx_vq;
  logic [CNT_W-1:0] exp_cnt;
  logic [7:0]       run_left;
  logic [7:0]       miss_left;
  logic             well_formed;
  logic             hit;

  always_comb begin
    well_formed = (rx_q[SEG_W-1 -: TAG_W] == TAG_V);
    for (int s = 1; s < NSEG; s++) begin
      if (rx_q[s*SEG_W +: SEG_W] != rx_q[SEG_W-1:0]) well_formed = 1'b0;
    end
    hit = (rx_q == pat_word(exp_cnt));
  end

  // run_left/miss_left are down-counters; terminal count 1 triggers the transition
  always_ff @(posedge m_wr_clk) begin
    if (m_wr_rst) begin
      state     <= SEARCH;
      rx_q      <= '0;
      rx_vq     <= 1'b0;
      exp_cnt   <= '0;
      run_left  <= '0;
      miss_left <= '0;
      locked    <= 1'b0;
      err_cnt   <= '0;
      good_cnt  <= '0;
    end else begin
      rx_q  <= rx_word;
      rx_vq <= rx_v;
      if (rx_vq) begin
        unique case (state)
          SEARCH: begin
            if (well_formed) begin
              exp_cnt   <= rx_q[CNT_W-1:0] + CNT_W'(1);
              run_left  <= RUN_LOAD;
              miss_left <= MISS_LOAD;
              state     <= VERIFY;
            end
          end
          VERIFY: begin
            exp_cnt <= exp_cnt + CNT_W'(1);
            if (!hit) begin
              state <= SEARCH;
            end else if (run_left == 8'd1) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              run_left <= run_left - 8'd1;
            end
          end
          LOCKED: begin
            exp_cnt <= exp_cnt + CNT_W'(1);
            if (hit) begin
              miss_left <= MISS_LOAD;
            end else if (miss_left == 8'd1) begin
              state  <= SEARCH;
              locked <= 1'b0;
            end else begin
              miss_left <= miss_left - 8'd1;
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
      if (clr_cnt) begin
        err_cnt  <= '0;
        good_cnt <= '0;
      end else if (rx_vq && state == LOCKED) begin
        if (hit && good_cnt != '1) good_cnt <= good_cnt + 32'(1);
        if (!hit && err_cnt != '1) err_cnt <= err_cnt + 16'(1);
      end
    end
  end

endmodule

// File: rtl/mac_ch_lpbk_chk.sv
// Multi-channel loopback traffic generator and checker; one lane per channel.
// Defining MAC_CH_LPBK_ERR_INJ_EN adds the inj_err port for TX error injection.
module mac_ch_lpbk_chk
  import mac_ch_lpbk_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int DWIDTH     = 40,
  parameter int RATIO      = 2,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                m_wr_clk,
  input  logic                m_wr_rst,
  input  logic                clr_cnt,
`ifdef MAC_CH_LPBK_ERR_INJ_EN
  input  logic [NCH-1:0]      inj_err,
`endif
  mac_ch_lpbk_chk_if.master   bus,
  output logic [NCH-1:0]      locked,
  output logic [NCH*16-1:0]   err_cnt,
  output logic [NCH*32-1:0]   good_cnt
);

  localparam int W = DWIDTH * RATIO;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    mac_ch_lpbk_lane #(
      .W          (W),
      .TAG        (c + 1),
      .LOCK_CNT   (LOCK_CNT),
      .UNLOCK_CNT (UNLOCK_CNT)
    ) u_lane (
      .m_wr_clk (m_wr_clk),
      .m_wr_rst (m_wr_rst),
      .tx_en    (bus.tx_transfer_en[c]),
      .rx_v     (bus.rx_transfer_en[c] & bus.m_rx_align_done),
      .clr_cnt  (clr_cnt),
`ifdef MAC_CH_LPBK_ERR_INJ_EN
      .inj_err  (inj_err[c]),
`endif
      .tx_word  (bus.data_in[c*W +: W]),
      .rx_word  (bus.data_out[c*W +: W]),
      .locked   (locked[c]),
      .err_cnt  (err_cnt[c*16 +: 16]),
      .good_cnt (good_cnt[c*32 +: 32])
    );
  end

endmodule
